// File: rtl/misalign_trap_unit.sv
// misalign_trap_unit: flags misaligned fetch/load-store addresses and captures one precise trap
// into a valid/ready handshake, with a saturating event counter and sticky drop flag.
module misalign_trap_unit #(
   parameter int XLEN   = 32,
   parameter int IALIGN = 32,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             cpu_rstn,
   input  logic             fetch_valid,
   input  logic [XLEN-1:0]  fetch_addr,
   input  logic             ls_valid,
   input  logic             ls_we,
   input  logic [1:0]       ls_size,
   input  logic [XLEN-1:0]  ls_addr,
   output logic             fetch_addr_misaligned,
   output logic             ls_addr_misaligned,
   output logic             trap_valid,
   input  logic             trap_ready,
   output logic [3:0]       trap_cause,
   output logic [XLEN-1:0]  trap_tval,
   output logic [CNT_W-1:0] err_count,
   output logic             trap_dropped,
   input  logic             clr_count
);
   typedef enum logic {IDLE, PENDING} state_t;
   state_t state, state_n;
   logic any, hs, capture, drop;
   logic [3:0] cause_n;
   logic [XLEN-1:0] tval_n;
   logic [CNT_W:0] sum;
   logic [CNT_W-1:0] count_n;
   always_comb begin
      fetch_addr_misaligned = fetch_valid & (IALIGN == 32 ? |fetch_addr[1:0] : fetch_addr[0]);
      ls_addr_misaligned = ls_valid & (ls_size == 2'd0 ? 1'b0 :
                                       ls_size == 2'd1 ? ls_addr[0] :
                                       ls_size == 2'd2 ? |ls_addr[1:0] : |ls_addr[2:0]);
      any = fetch_addr_misaligned | ls_addr_misaligned;
      trap_valid = state == PENDING;
      hs = trap_valid & trap_ready;
      // a handshake frees the slot in the same cycle, so a new trap can be taken without a bubble
      capture = any & (state == IDLE | hs);
      drop = any & (state == PENDING) & ~hs;
      state_n = capture ? PENDING : hs ? IDLE : state;
      cause_n = fetch_addr_misaligned ? 4'd0 : ls_we ? 4'd6 : 4'd4;
      tval_n = fetch_addr_misaligned ? fetch_addr : ls_addr;
      sum = {1'b0, err_count} + (CNT_W+1)'(fetch_addr_misaligned) + (CNT_W+1)'(ls_addr_misaligned);
      count_n = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   end
   always_ff @(posedge clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state <= IDLE;
         trap_cause <= '0;
         trap_tval <= '0;
      end else begin
         state <= state_n;
         if (capture) begin
            trap_cause <= cause_n;
            trap_tval <= tval_n;
         end
      end
   end
   always_ff @(posedge clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         err_count <= '0;
         trap_dropped <= 1'b0;
      end else if (clr_count) begin
         err_count <= '0;
         trap_dropped <= 1'b0;
      end else begin
         err_count <= count_n;
         trap_dropped <= trap_dropped | drop;
      end
   end
endmodule

// File: tb/tb_misalign_trap_unit.sv
// tb_misalign_trap_unit: scoreboard bench; a monitor pops expected traps at each handshake,
// a second instance covers IALIGN=16 and a 2-bit counter.
module tb_misalign_trap_unit;
   logic clk = 0, cpu_rstn = 0;
   logic fetch_valid = 0, ls_valid = 0, ls_we = 0, trap_ready = 1, clr_count = 0;
   logic [1:0] ls_size = 0;
   logic [31:0] fetch_addr = 0, ls_addr = 0;
   logic fm, lm, tv, td, fm16, lm16, tv16, td16;
   logic [3:0] tc, tc16;
   logic [31:0] tt, tt16;
   logic [7:0] ec;
   logic [1:0] ec16;
   int checks = 0, failures = 0;
   logic [35:0] exp_q[$];
   always #5 clk = ~clk;

   misalign_trap_unit #(.XLEN(32), .IALIGN(32), .CNT_W(8)) dut (
      .clk(clk), .cpu_rstn(cpu_rstn), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
      .ls_valid(ls_valid), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
      .fetch_addr_misaligned(fm), .ls_addr_misaligned(lm), .trap_valid(tv), .trap_ready(trap_ready),
      .trap_cause(tc), .trap_tval(tt), .err_count(ec), .trap_dropped(td), .clr_count(clr_count));
   misalign_trap_unit #(.XLEN(32), .IALIGN(16), .CNT_W(2)) dut16 (
      .clk(clk), .cpu_rstn(cpu_rstn), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
      .ls_valid(ls_valid), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
      .fetch_addr_misaligned(fm16), .ls_addr_misaligned(lm16), .trap_valid(tv16), .trap_ready(trap_ready),
      .trap_cause(tc16), .trap_tval(tt16), .err_count(ec16), .trap_dropped(td16), .clr_count(clr_count));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fv, input logic [31:0] fa, input logic lv, input logic we,
                        input logic [1:0] sz, input logic [31:0] la);
      fetch_valid = fv; fetch_addr = fa; ls_valid = lv; ls_we = we; ls_size = sz; ls_addr = la;
      #1;
   endtask

   task automatic idle();
      drive(0, 32'h0, 0, 0, 2'd0, 32'h0);
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   initial begin : monitor
      logic [35:0] e;
      forever begin
         @(negedge clk);
         if (cpu_rstn && tv && trap_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_trap", {tc, tt}, 36'h0);
            end else begin
               e = exp_q.pop_front();
               chk("hs_cause", 64'(tc), 64'(e[35:32]));
               chk("hs_tval", 64'(tt), 64'(e[31:0]));
            end
         end
      end
   end

   initial begin : watchdog
      #20000;
      $display("FAIL watchdog: timeout");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] mask [4];
      mask[0] = 8'h00; mask[1] = 8'hAA; mask[2] = 8'hEE; mask[3] = 8'hFE;
      #2;
      chk("rst_valid", 64'(tv), 0);
      chk("rst_cause", 64'(tc), 0);
      chk("rst_tval", 64'(tt), 0);
      chk("rst_count", 64'(ec), 0);
      chk("rst_dropped", 64'(td), 0);
      // flags follow inputs while held in reset, so the sweep cannot spawn traps
      for (int s = 0; s < 4; s++)
         for (int a = 0; a < 8; a++)
            for (int w = 0; w < 2; w++) begin
               drive(0, 32'h0, 1, w[0], s[1:0], 32'h1230 + 32'(a));
               chk($sformatf("ls_flag_s%0d_a%0d_w%0d", s, a, w), 64'(lm), 64'(mask[s][a]));
            end
      drive(0, 32'h0, 0, 0, 2'd3, 32'h7);
      chk("ls_flag_novalid", 64'(lm), 0);
      drive(0, 32'h3, 0, 0, 2'd0, 32'h0);
      chk("fetch_flag_novalid", 64'(fm), 0);
      chk("rst_hold_valid", 64'(tv), 0);
      idle();
      @(negedge clk); cpu_rstn = 1;
      cyc();
      drive(1, 32'h1002, 0, 0, 2'd0, 32'h0);
      chk("fetch_flag32", 64'(fm), 1);
      chk("fetch_flag16", 64'(fm16), 0);
      exp_q.push_back({4'd0, 32'h1002});
      cyc(); idle();
      chk("fetch_valid", 64'(tv), 1);
      chk("fetch_cause", 64'(tc), 0);
      chk("fetch_tval", 64'(tt), 32'h1002);
      chk("fetch_count", 64'(ec), 1);
      chk("a16_no_trap", 64'(tv16), 0);
      chk("a16_count", 64'(ec16), 0);
      cyc();
      drive(0, 32'h0, 1, 1, 2'd2, 32'h2001);
      exp_q.push_back({4'd6, 32'h2001});
      cyc(); idle();
      chk("store_cause", 64'(tc), 6);
      chk("store_tval", 64'(tt), 32'h2001);
      cyc();
      drive(0, 32'h0, 1, 0, 2'd2, 32'h2001);
      exp_q.push_back({4'd4, 32'h2001});
      cyc(); idle();
      chk("load_cause", 64'(tc), 4);
      chk("count_3", 64'(ec), 3);
      chk("c2_count_2", 64'(ec16), 2);
      cyc();
      drive(1, 32'h3, 1, 0, 2'd1, 32'h5);
      chk("both_fm", 64'(fm), 1);
      chk("both_lm", 64'(lm), 1);
      exp_q.push_back({4'd0, 32'h3});
      cyc(); idle();
      chk("both_cause", 64'(tc), 0);
      chk("both_tval", 64'(tt), 32'h3);
      chk("both_count", 64'(ec), 5);
      chk("c2_sat_plus2", 64'(ec16), 3);
      cyc();
      trap_ready = 0;
      drive(0, 32'h0, 1, 0, 2'd2, 32'h6);
      exp_q.push_back({4'd4, 32'h6});
      cyc();
      drive(0, 32'h0, 1, 1, 2'd1, 32'h7);
      cyc(); idle();
      chk("held_valid", 64'(tv), 1);
      chk("held_cause", 64'(tc), 4);
      chk("held_tval", 64'(tt), 32'h6);
      chk("dropped_set", 64'(td), 1);
      chk("held_count", 64'(ec), 7);
      trap_ready = 1;
      drive(0, 32'h0, 1, 0, 2'd2, 32'h4003);
      exp_q.push_back({4'd4, 32'h4003});
      cyc(); idle();
      chk("b2b_valid", 64'(tv), 1);
      chk("b2b_cause", 64'(tc), 4);
      chk("b2b_tval", 64'(tt), 32'h4003);
      chk("b2b_count", 64'(ec), 8);
      cyc();
      chk("b2b_idle", 64'(tv), 0);
      chk("c2_hold_max", 64'(ec16), 3);
      clr_count = 1;
      drive(1, 32'h1, 0, 0, 2'd0, 32'h0);
      exp_q.push_back({4'd0, 32'h1});
      cyc(); idle();
      clr_count = 0;
      chk("clr_count", 64'(ec), 0);
      chk("clr_dropped", 64'(td), 0);
      chk("clr_count16", 64'(ec16), 0);
      chk("clr_dropped16", 64'(td16), 0);
      chk("clr_trap_taken", 64'(tv), 1);
      cyc();
      chk("clr_stays0", 64'(ec), 0);
      trap_ready = 0;
      drive(1, 32'h12, 0, 0, 2'd0, 32'h0);
      cyc(); idle();
      chk("pre_rst_valid", 64'(tv), 1);
      chk("pre_rst_count", 64'(ec), 1);
      #2 cpu_rstn = 0;
      #1;
      chk("async_valid", 64'(tv), 0);
      chk("async_cause", 64'(tc), 0);
      chk("async_tval", 64'(tt), 0);
      chk("async_count", 64'(ec), 0);
      @(negedge clk); cpu_rstn = 1;
      trap_ready = 1;
      cyc(); cyc();
      chk("post_rst_valid", 64'(tv), 0);
      chk("scoreboard_empty", 64'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/misalign_trap_unit.md
Name: misalign_trap_unit

Overview:
- Parametrised successor to the single-channel fetch misalignment check. Monitors the instruction-fetch and load/store address channels of the core.
- Flags misaligned accesses combinationally.
- Captures one precise trap (cause + tval) into a registered valid/ready handshake toward the trap/CSR logic.
- Keeps a saturating error counter and a sticky dropped-trap flag for debug.

Parameters:
- XLEN, 32, address/data width (32 or 64).
- IALIGN, 32, instruction alignment in bits. 32 = 4-byte fetch alignment; 16 = 2-byte (C extension).
- CNT_W, 8, width of the misalignment event counter.

Ports:
- clk  in  1  core clock
- cpu_rstn  in  1  asynchronous active-low reset
- fetch_valid  in  1  fetch request valid
- fetch_addr  in  XLEN  fetch PC
- ls_valid  in  1  load/store request valid
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword
- ls_addr  in  XLEN  load/store effective address
- fetch_addr_misaligned  out  1  combinational fetch misalign flag
- ls_addr_misaligned  out  1  combinational load/store misalign flag
- trap_valid  out  1  captured trap pending
- trap_ready  in  1  trap consumer accepts
- trap_cause  out  4  RISC-V mcause code: 0 instr, 4 load, 6 store
- trap_tval  out  XLEN  faulting address
- err_count  out  CNT_W  saturating misalignment event count
- trap_dropped  out  1  sticky: misalign occurred while a trap was pending
- clr_count  in  1  synchronous clear of err_count and trap_dropped

Behaviour:

Detection (combinational):
- fetch_addr_misaligned = fetch_valid & (IALIGN==32 ? fetch_addr[1:0]!=0 : fetch_addr[0]!=0).
- ls_addr_misaligned = ls_valid & (low ls_size bits of ls_addr nonzero).
  - size 0: never misaligned
  - size 1: addr[0] set
  - size 2: addr[1:0] nonzero
  - size 3: addr[2:0] nonzero; this check applies even when XLEN=32
- Both flags are 0 whenever the corresponding valid is 0, regardless of the address.

Trap FSM (2 states):
- IDLE
  - trap_valid=0.
  - If any flag is set: capture and go to PENDING.
  - Priority: fetch over load/store. Cause 0 with tval=fetch_addr; otherwise cause 4 (ls_we=0) or 6 (ls_we=1) with tval=ls_addr.
- PENDING
  - trap_valid=1.
  - trap_cause and trap_tval are held stable until the trap_valid & trap_ready handshake.
  - Any misalign flag in PENDING, other than in the handshake cycle, is not captured and sets trap_dropped.
- Handshake cycle (trap_valid & trap_ready)
  - If a flag is set in the same cycle: capture the new trap and stay PENDING (back-to-back, no bubble, not dropped).
  - Otherwise: go to IDLE.
- Capture latency: flag in cycle N gives trap_valid=1 in cycle N+1.

Counter:
- err_count increments by (fetch_addr_misaligned + ls_addr_misaligned) each cycle, range 0..2, in any FSM state.
- Saturates at 2^CNT_W-1 with no wrap. A +2 step from max-1 lands on max.
- clr_count has priority over same-cycle increments: err_count=0 and trap_dropped=0 next cycle. Events in the clear cycle are not counted and do not set trap_dropped.

Reset:
- Asynchronous on cpu_rstn low: FSM to IDLE, trap_valid=0, trap_cause=0, trap_tval=0, err_count=0, trap_dropped=0.
- Reset mid-PENDING discards the pending trap with no handshake.
- The combinational flags still follow their inputs during reset.

Test Plan:
- IALIGN=32, fetch_valid=1, fetch_addr=0x1002 -> fetch_addr_misaligned=1 same cycle; next cycle trap_valid=1, trap_cause=0, trap_tval=0x1002, err_count=1. With IALIGN=16, same stimulus -> no flag, no trap.
- Sweep ls_size 0..3 across ls_addr[2:0]=0..7 with ls_we=0/1 -> flag exactly per the size rule. Store at 0x2001 size 2 -> trap_cause=6, tval=0x2001; load -> trap_cause=4.
- Same cycle: fetch_addr=0x3 and ls_addr=0x5 size 1, both valid -> captured cause=0, tval=0x3; err_count increments by 2.
- Hold trap_ready=0 while a second misalign arrives -> cause/tval unchanged, trap_dropped=1. Then trap_ready=1 together with a new load misalign at 0x4003 size 2 -> next cycle trap_valid stays 1 with cause=4, tval=0x4003.
- CNT_W=2: drive 5 misaligned events -> err_count=3 and holds. Assert clr_count with a simultaneous event -> err_count=0, trap_dropped=0.
- Assert cpu_rstn=0 mid-PENDING, asynchronously between clock edges -> trap_valid, trap_cause, trap_tval and err_count go to 0 immediately. After release with no misalign, trap_valid stays 0.
